ceas_alarma: RTL and testbench
==============================

# ceas_alarma

Timekeeping and alarm core that receives the time/alarm setting interface driven by the `setare` block: `ore`, `minute`, `load_timp`, `load_alarma`, `semnal_stop`. It holds the running time (hh:mm:ss) from a prescaled system clock, latches the alarm time, and runs a small FSM that raises `alarma` on an hh:mm match at minute rollover. It feeds the display and buzzer logic downstream.

## Interface
- `DIV`, default 50_000_000: clock cycles per second; allowed range ≥ 2. Benches use small values.
- `RING_SEC`, default 60: maximum ring duration in seconds before auto-stop; allowed range 1..63.

- `clock`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ore`  in  5  hour value from `setare`, valid 0..23.
- `minute`  in  6  minute value from `setare`, valid 0..59.
- `load_timp`  in  1  one-cycle strobe: load `ore`/`minute` into current time.
- `load_alarma`  in  1  one-cycle strobe: load `ore`/`minute` into alarm time and arm.
- `semnal_stop`  in  1  level: silence a ringing alarm.
- `ore_curent`  out  5  current hour, 0..23.
- `minute_curent`  out  6  current minute, 0..59.
- `secunde`  out  6  current second, 0..59.
- `ore_alarma`  out  5  stored alarm hour.
- `minute_alarma`  out  6  stored alarm minute.
- `alarma_setata`  out  1  alarm is armed.
- `alarma`  out  1  alarm ringing.

## Operation
- **Reset (`reset`=0)** clears every output, the prescaler, and the ring counter to 0. The FSM goes to OPRIT.
- **Prescaler:** counts 0..DIV-1. Its wrap (DIV-1→0) is the second tick.
- **On a second tick:**
  - `secunde` increments, wrapping 59→0.
  - On that wrap, `minute_curent` increments, wrapping 59→0.
  - On the minute wrap, `ore_curent` increments, wrapping 23→0.
  - 23:59:59 → 00:00:00.
- **Load validity:** a load is valid only if `ore`≤23 and `minute`≤59. An invalid load is ignored entirely and no register changes.
- **`load_timp` (valid):**
  - `ore_curent`/`minute_curent` take the inputs.
  - `secunde` and the prescaler clear to 0.
  - A concurrent second tick is discarded; the load wins.
  - A load never generates a minute rollover event.
- **`load_alarma` (valid):**
  - `ore_alarma`/`minute_alarma` take the inputs and `alarma_setata` becomes 1.
  - Both strobes valid in the same cycle → both loads apply with the same values.
- **Rollover event:** an internal registered pulse, high for the one cycle after the edge on which `secunde` wraps 59→0 through counting.
- **FSM states:**
  - OPRIT: `alarma_setata`=0, `alarma`=0.
  - ARMAT: `alarma_setata`=1, `alarma`=0.
  - SUNA: `alarma_setata`=1, `alarma`=1.
- **FSM transitions:**
  - OPRIT→ARMAT on a valid `load_alarma`.
  - ARMAT→SUNA when the rollover event is high and `ore_curent`==`ore_alarma` and `minute_curent`==`minute_alarma`. The ring counter clears on entry.
  - SUNA→ARMAT when `semnal_stop`=1. The alarm stays armed for the next day.
  - SUNA→ARMAT when the ring counter, incremented on each second tick, reaches RING_SEC.
  - SUNA + valid `load_alarma` → ARMAT with the new alarm values. This takes priority over a simultaneous `semnal_stop`.
  - `semnal_stop` in OPRIT or ARMAT has no effect.
  - `load_timp` in SUNA does not stop ringing.

## Timing
- Second tick every DIV cycles after reset release or after the last `load_timp`. The first tick occurs DIV cycles after either event.
- Load latency: one edge. The strobe is sampled at edge N and outputs show the new values after edge N.
- Alarm latency:
  - Time registers show hh:mm:00 after edge N.
  - The rollover event is high during cycle N→N+1.
  - `alarma`=1 after edge N+1.
- Stop latency: `semnal_stop` sampled high at edge N → `alarma`=0 after edge N.
- Auto-stop: `alarma` deasserts after the edge of the RING_SEC-th second tick counted from entry into SUNA.
- Asynchronous reset takes effect immediately, including mid-ring. Outputs are 0 while `reset`=0.

## Test plan
- **Reset values:** hold `reset`=0 for 3 cycles with any inputs → all outputs 0. Release, run 4 ticks with DIV=4 → `secunde`=4 after 16 cycles.
- **Time load and wrap:** DIV=2. Pulse `load_timp` with ore=23, minute=59. After 60 ticks → 00:00:00. One more tick → 00:00:01.
- **Invalid load:** pulse `load_timp` with ore=24, minute=10, then with ore=5, minute=60 → time unchanged and counting continues.
- **Alarm ring and stop:**
  - DIV=2. Load alarm 07:30 → `alarma_setata`=1. Load time 07:29.
  - `alarma` rises exactly 1 cycle after 07:30:00 appears.
  - Assert `semnal_stop` → `alarma`=0 next edge, `alarma_setata` stays 1.
- **No ring from load; auto-stop:**
  - Load alarm 12:00, then load time 12:00 → no ring.
  - Load time 11:59 and let it ring with RING_SEC=3 and no stop → `alarma` high for exactly 3 ticks, then ARMAT.
- **Simultaneous events:**
  - `load_timp` coinciding with the prescaler wrap → `secunde`=0.
  - `load_alarma` with `semnal_stop` during SUNA → new alarm stored, `alarma`=0.
  - `reset` pulled low mid-ring → `alarma`=0 immediately.

Source files
------------

// File: rtl/ceas_alarma.sv
// Timekeeping and alarm core: prescaled hh:mm:ss clock, alarm register and
// a three-state alarm FSM that rings on an hh:mm match at minute rollover.
module ceas_alarma #(
  parameter int unsigned DIV      = 50_000_000,
  parameter int unsigned RING_SEC = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] ore,
  input  logic [5:0] minute,
  input  logic       load_timp,
  input  logic       load_alarma,
  input  logic       semnal_stop,
  output logic [4:0] ore_curent,
  output logic [5:0] minute_curent,
  output logic [5:0] secunde,
  output logic [4:0] ore_alarma,
  output logic [5:0] minute_alarma,
  output logic       alarma_setata,
  output logic       alarma
);

  localparam int unsigned   PW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [5:0]    RING_LAST = 6'(RING_SEC - 1);

  typedef enum logic [1:0] {OPRIT, ARMAT, SUNA} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hr_q, hr_d, ahr_q, ahr_d;
  logic [5:0]    mn_q, mn_d, sc_q, sc_d, amn_q, amn_d;
  logic [5:0]    ring_q, ring_d;
  logic          roll_q, roll_d;
  logic          in_ok, ld_t, ld_a, wrap, tick, match;

  always_comb begin
    in_ok = (ore <= 5'd23) && (minute <= 6'd59);
    ld_t  = load_timp && in_ok;
    ld_a  = load_alarma && in_ok;
    wrap  = (presc_q == PRESC_MAX);
    // a valid time load swallows a coincident prescaler wrap
    tick  = wrap && !ld_t;
    match = roll_q && (hr_q == ahr_q) && (mn_q == amn_q);
  end

  always_comb begin
    presc_d = presc_q;
    hr_d    = hr_q;
    mn_d    = mn_q;
    sc_d    = sc_q;
    ahr_d   = ahr_q;
    amn_d   = amn_q;
    roll_d  = tick && (sc_q == 6'd59);
    if (ld_t) begin
      hr_d    = ore;
      mn_d    = minute;
      sc_d    = '0;
      presc_d = '0;
    end else if (wrap) begin
      presc_d = '0;
      if (sc_q == 6'd59) begin
        sc_d = '0;
        if (mn_q == 6'd59) begin
          mn_d = '0;
          hr_d = (hr_q == 5'd23) ? '0 : hr_q + 5'd1;
        end else begin
          mn_d = mn_q + 6'd1;
        end
      end else begin
        sc_d = sc_q + 6'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (ld_a) begin
      ahr_d = ore;
      amn_d = minute;
    end
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    case (state_q)
      OPRIT: if (ld_a) state_d = ARMAT;
      ARMAT: begin
        if (!ld_a && match) begin
          state_d = SUNA;
          ring_d  = '0;
        end
      end
      SUNA: begin
        if (ld_a || semnal_stop) begin
          state_d = ARMAT;
        end else if (tick) begin
          if (ring_q == RING_LAST) state_d = ARMAT;
          else                     ring_d  = ring_q + 6'd1;
        end
      end
      default: state_d = OPRIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= OPRIT;
      presc_q <= '0;
      hr_q    <= '0;
      mn_q    <= '0;
      sc_q    <= '0;
      ahr_q   <= '0;
      amn_q   <= '0;
      ring_q  <= '0;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hr_q    <= hr_d;
      mn_q    <= mn_d;
      sc_q    <= sc_d;
      ahr_q   <= ahr_d;
      amn_q   <= amn_d;
      ring_q  <= ring_d;
      roll_q  <= roll_d;
    end
  end

  assign ore_curent    = hr_q;
  assign minute_curent = mn_q;
  assign secunde       = sc_q;
  assign ore_alarma    = ahr_q;
  assign minute_alarma = amn_q;
  assign alarma_setata = (state_q != OPRIT);
  assign alarma        = (state_q == SUNA);

endmodule

// File: tb/tb_ceas_alarma.sv
// Bench for ceas_alarma: seconds-of-day reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ceas_alarma;
  localparam int DIV      = 4;
  localparam int RING_SEC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] i_ore = '0;
  logic [5:0] i_min = '0;
  logic       i_lt = 1'b0, i_la = 1'b0, i_st = 1'b0;
  logic [4:0] ore_curent, ore_alarma;
  logic [5:0] minute_curent, secunde, minute_alarma;
  logic       alarma_setata, alarma;

  int checks = 0;
  int errors = 0;

  // reference model state: time as seconds of day, alarm as minutes of day
  int m_tod = 0, m_phase = 0, m_alarm = 0, m_rcnt = 0;
  bit m_armed = 0, m_ring = 0, m_roll = 0;

  ceas_alarma #(.DIV(DIV), .RING_SEC(RING_SEC)) dut (
    .clock(clk), .reset(rst_n), .ore(i_ore), .minute(i_min),
    .load_timp(i_lt), .load_alarma(i_la), .semnal_stop(i_st),
    .ore_curent(ore_curent), .minute_curent(minute_curent), .secunde(secunde),
    .ore_alarma(ore_alarma), .minute_alarma(minute_alarma),
    .alarma_setata(alarma_setata), .alarma(alarma)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    int  h, m, cur_min;
    bit  ok, ltv, lav, wrap, et, new_roll;
    if (!rst_n) begin
      m_tod = 0; m_phase = 0; m_alarm = 0; m_rcnt = 0;
      m_armed = 0; m_ring = 0; m_roll = 0;
    end else begin
      h = int'(i_ore);
      m = int'(i_min);
      ok = (h <= 23) && (m <= 59);
      ltv = i_lt && ok;
      lav = i_la && ok;
      wrap = (m_phase == DIV - 1);
      et = wrap && !ltv;
      cur_min = m_tod / 60;
      if (m_ring) begin
        if (lav || i_st) m_ring = 0;
        else if (et) begin
          m_rcnt++;
          if (m_rcnt == RING_SEC) m_ring = 0;
        end
      end else if (m_armed) begin
        if (!lav && m_roll && cur_min == m_alarm) begin
          m_ring = 1;
          m_rcnt = 0;
        end
      end
      if (lav) begin
        m_alarm = h * 60 + m;
        m_armed = 1;
      end
      new_roll = et && (m_tod % 60 == 59);
      if (ltv) begin
        m_tod = h * 3600 + m * 60;
        m_phase = 0;
      end else if (wrap) begin
        m_tod = (m_tod + 1) % 86400;
        m_phase = 0;
      end else begin
        m_phase++;
      end
      m_roll = new_roll;
    end
  end

  always @(negedge clk) begin
    chk("ore_curent",    int'(ore_curent),    m_tod / 3600);
    chk("minute_curent", int'(minute_curent), (m_tod / 60) % 60);
    chk("secunde",       int'(secunde),       m_tod % 60);
    chk("ore_alarma",    int'(ore_alarma),    m_alarm / 60);
    chk("minute_alarma", int'(minute_alarma), m_alarm % 60);
    chk("alarma_setata", int'(alarma_setata), int'(m_armed));
    chk("alarma",        int'(alarma),        int'(m_ring));
  end

  task automatic pulse(input bit lt, input bit la, input bit st, input int h, input int m);
    i_lt = lt; i_la = la; i_st = st;
    i_ore = 5'(h); i_min = 6'(m);
    @(negedge clk);
    i_lt = 1'b0; i_la = 1'b0; i_st = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r, am;
    #1 rst_n = 1'b0;
    i_lt = 1'b1; i_la = 1'b1; i_st = 1'b1; i_ore = 5'd5; i_min = 6'd6;
    wait_cyc(3);
    chk("rst_time", {ore_curent, minute_curent, secunde}, 0);
    chk("rst_alarm", {ore_alarma, minute_alarma, alarma_setata, alarma}, 0);
    i_lt = 1'b0; i_la = 1'b0; i_st = 1'b0;
    rst_n = 1'b1;
    wait_cyc(16);
    chk("sec_after_16", secunde, 4);

    pulse(1, 0, 0, 23, 59);
    chk("load_2359", {ore_curent, minute_curent, secunde}, {5'd23, 6'd59, 6'd0});
    wait_cyc(240);
    chk("wrap_midnight", {ore_curent, minute_curent, secunde}, 0);
    wait_cyc(4);
    chk("after_wrap", secunde, 1);
    pulse(1, 0, 0, 24, 10);
    chk("bad_hour", {ore_curent, minute_curent, secunde}, 1);
    pulse(1, 0, 0, 5, 60);
    chk("bad_min", {ore_curent, minute_curent, secunde}, 1);
    wait_cyc(2);
    chk("count_on", secunde, 2);

    pulse(0, 1, 0, 7, 30);
    chk("alarm_set", {ore_alarma, minute_alarma, alarma_setata}, {5'd7, 6'd30, 1'b1});
    pulse(1, 0, 0, 7, 29);
    wait_cyc(240);
    chk("at_0730", {ore_curent, minute_curent, secunde, alarma}, {5'd7, 6'd30, 6'd0, 1'b0});
    wait_cyc(1);
    chk("ring_rise", alarma, 1);
    pulse(0, 0, 1, 0, 0);
    chk("stop", {alarma_setata, alarma}, 2'b10);

    pulse(0, 1, 0, 12, 0);
    pulse(1, 0, 0, 12, 0);
    wait_cyc(8);
    chk("no_ring_load", alarma, 0);
    pulse(1, 0, 0, 11, 59);
    wait_cyc(241);
    chk("ring2_rise", alarma, 1);
    wait_cyc(10);
    chk("ring2_hold", alarma, 1);
    wait_cyc(1);
    chk("auto_stop", {alarma_setata, alarma}, 2'b10);

    wait_cyc(3);
    pulse(1, 0, 0, 3, 4);
    chk("load_at_wrap", {ore_curent, minute_curent, secunde}, {5'd3, 6'd4, 6'd0});
    wait_cyc(3);
    chk("presc_restart0", secunde, 0);
    wait_cyc(1);
    chk("presc_restart1", secunde, 1);

    pulse(0, 1, 0, 3, 5);
    pulse(1, 0, 0, 3, 4);
    wait_cyc(241);
    chk("ring3_rise", alarma, 1);
    pulse(0, 1, 1, 9, 15);
    chk("la_over_stop", {ore_alarma, minute_alarma, alarma_setata, alarma},
        {5'd9, 6'd15, 1'b1, 1'b0});

    pulse(1, 0, 0, 9, 14);
    wait_cyc(241);
    chk("ring4_rise", alarma, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {alarma_setata, alarma, ore_curent}, 0);
    wait_cyc(2);
    rst_n = 1'b1;

    for (int i = 0; i < 5000; i++) begin
      r = $urandom_range(0, 999);
      i_lt = (r < 6);
      i_la = (r >= 5 && r < 9);
      i_st = ($urandom_range(0, 99) < 3);
      i_ore = 5'($urandom_range(0, 25));
      i_min = 6'($urandom_range(0, 63));
      if (i_lt && $urandom_range(0, 1) == 1) begin
        am = (m_alarm + 1439) % 1440;
        i_ore = 5'(am / 60); i_min = 6'(am % 60);
      end else if (i_la && $urandom_range(0, 1) == 1) begin
        am = (m_tod / 60 + 1) % 1440;
        i_ore = 5'(am / 60); i_min = 6'(am % 60);
      end
      @(negedge clk);
    end
    i_lt = 1'b0; i_la = 1'b0; i_st = 1'b0;
    wait_cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
